// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// fifo_rd_streamer : drains an async FIFO read port into a valid/ready stream
// framed in BURST_LEN-word bursts.  Revision: 1.0
// ============================================================================
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic                  busy
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;
  logic                  inflight;
  logic [BEAT_W-1:0]     beat;
  logic                  hs;
  logic [2:0]            avail;

  assign hs = m_valid && m_ready;

  // Slots already claimed after this cycle's handshake; an in-flight word
  // owns a slot, so popping only below 2 keeps the buffer from overflowing.
  assign avail     = {1'b0, cnt} + {2'b00, inflight} - {2'b00, hs};
  assign fifo_r_en = !rst && enable && !fifo_empty && (avail < 3'd2);

  assign m_valid = (cnt != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid && (beat == LAST_BEAT);
  assign busy    = (cnt != 2'd0) || inflight;

  always_ff @(posedge r_clk) begin
    if (rst) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      cnt        <= 2'd0;
      inflight   <= 1'b0;
      beat       <= '0;
      words_sent <= '0;
    end else begin
      inflight <= fifo_r_en;
      // The FIFO presents the popped word one cycle after r_en.
      if (inflight) begin
        mem[wr_ptr] <= fifo_r_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (hs) begin
        rd_ptr     <= ~rd_ptr;
        words_sent <= words_sent + 1'b1;
        beat       <= m_last ? '0 : beat + 1'b1;
      end
      cnt <= cnt + {1'b0, inflight} - {1'b0, hs};
    end
  end

  a_no_overflow : assert property (@(posedge r_clk) disable iff (rst)
                                   inflight |-> (cnt != 2'd2));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_streamer : directed + random bench with a FIFO model and a
// stream scoreboard.  Revision: 1.0
// ============================================================================
module tb_fifo_rd_streamer;

  localparam int DW = 16;
  localparam int BL = 4;
  localparam int CW = 8;

  logic          r_clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] words_sent;
  logic          busy;

  fifo_rd_streamer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .r_clk(r_clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_r_data(fifo_r_data), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .words_sent(words_sent), .busy(busy)
  );

  always #5 r_clk = ~r_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model with 1-cycle registered read
  logic [DW-1:0] fmem [0:1023];
  int            fw = 0;
  int            fr = 0;
  logic          fifo_flush = 1'b0;
  assign fifo_empty = (fr == fw);

  always @(posedge r_clk) begin
    if (fifo_flush) fr <= fw;
    else if (fifo_r_en) begin
      fifo_r_data <= fmem[fr[9:0]];
      fr <= fr + 1;
    end
  end

  // Reference: every pushed word comes out once, in order, framed by count
  logic [DW-1:0] exp_q [$];

  task automatic push(input logic [DW-1:0] d);
    fmem[fw[9:0]] = d;
    fw = fw + 1;
    exp_q.push_back(d);
  endtask

  int            n_del, n_pop, cyc, first_pop, first_hs, last_hs;
  logic          seen_valid, prev_valid, prev_ready;
  logic [DW-1:0] prev_data;

  always @(negedge r_clk) begin
    if (rst) begin
      n_del = 0; n_pop = 0; cyc = 0; first_pop = -1; first_hs = -1; last_hs = -1;
      seen_valid = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    end else begin
      cyc++;
      chk("busy", 64'(busy), 64'(n_pop != n_del));
      chk("occupancy", 64'((n_pop - n_del) <= 2), 64'd1);
      if (fifo_r_en) begin
        chk("pop_legal", 64'(!fifo_empty && enable), 64'd1);
        if (first_pop < 0) first_pop = cyc;
        n_pop++;
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(prev_data));
      end
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        chk("latency", 64'(cyc - first_pop), 64'd2);
      end
      chk("words_sent", 64'(words_sent), 64'(n_del % (1 << CW)));
      chk("last_qual", 64'(m_last && !m_valid), 64'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious", 64'd1, 64'd0);
        else begin
          chk("data", 64'(m_data), 64'(exp_q.pop_front()));
          chk("last", 64'(m_last), 64'((n_del % BL) == BL - 1));
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        n_del++;
      end
      prev_valid = m_valid; prev_ready = m_ready; prev_data = m_data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge r_clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_flush = 1'b1; enable = 1'b0; m_ready = 1'b0;
    step(2);
    exp_q.delete();
    fifo_flush = 1'b0; rst = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < maxc) begin step(1); k++; end
    chk("drain_timeout", 64'(k < maxc), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset holds everything at 0 even with data available
    enable = 1'b1;
    push(16'hABCD);
    repeat (3) begin
      @(posedge r_clk); @(negedge r_clk);
      chk("rst_r_en", 64'(fifo_r_en), 64'd0);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      chk("rst_last", 64'(m_last), 64'd0);
      chk("rst_cnt", 64'(words_sent), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    @(posedge r_clk); #1;
    do_reset();

    // 2: back-to-back streaming of 8 preloaded words
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
    enable = 1'b1;
    wait_drain(100);
    chk("t2_count", 64'(n_del), 64'd8);
    chk("t2_b2b", 64'(last_hs - first_hs), 64'd7);

    // 3: backpressure stops pops at 2 and holds the head word
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
    enable = 1'b1;
    step(10);
    chk("t3_pops", 64'(n_pop), 64'd2);
    chk("t3_head", 64'(m_data), 64'h1000);
    m_ready = 1'b1;
    wait_drain(100);
    chk("t3_count", 64'(n_del), 64'd8);

    // 4: enable drops right after a pop; that word still comes out
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(16'h4000 + 16'(i));
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(8);
    chk("t4_pops", 64'(n_pop), 64'd1);
    chk("t4_del", 64'(n_del), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    wait_drain(100);
    chk("t4_count", 64'(n_del), 64'd8);

    // 5: framing continues across an empty gap
    do_reset();
    m_ready = 1'b1; enable = 1'b1;
    push(16'h5000); push(16'h5001);
    wait_drain(50);
    chk("t5_part", 64'(n_del), 64'd2);
    step(5);
    push(16'h5002); push(16'h5003); push(16'h5004);
    wait_drain(50);
    chk("t5_count", 64'(n_del), 64'd5);

    // 6: reset with a full buffer discards everything and restarts framing
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h6000 + 16'(i));
    enable = 1'b1; m_ready = 1'b1;
    step(5);
    m_ready = 1'b0;
    step(4);
    chk("t6_full", 64'(n_pop - n_del), 64'd2);
    rst = 1'b1; fifo_flush = 1'b1;
    step(1);
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_cnt", 64'(words_sent), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_last", 64'(m_last), 64'd0);
    step(1);
    exp_q.delete();
    rst = 1'b0; fifo_flush = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(16'h2000 + 16'(i));
    wait_drain(100);
    chk("t6_count", 64'(n_del), 64'd5);

    // random traffic, long enough to wrap words_sent
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 3) != 0 && (fw - fr) < 8) push(16'($urandom));
      m_ready = ($urandom % 4) != 0;
      enable  = ($urandom % 8) != 0;
      step(1);
    end
    enable = 1'b1; m_ready = 1'b1;
    wait_drain(200);
    chk("rand_wrap", 64'(n_del > (1 << CW)), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
